// File: rtl/ddr_mon_pkg.sv
// Shared types and constants for the DDR app-interface monitor.
package ddr_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam int unsigned CMD_WR = 0;
  localparam int unsigned CMD_RD = 1;

  // Trace entry layout is {timestamp, cmd, addr}.
  function automatic int entry_w(input int ts_w, input int cmd_w, input int addr_w);
    return ts_w + cmd_w + addr_w;
  endfunction

endpackage

// File: rtl/ddr_app_monitor_if.sv
// MIG user (app) interface bundle; the monitor only ever listens through the slave view.
interface ddr_app_monitor_if #(
  parameter int ADDR_W = 28,
  parameter int CMD_W  = 3
);
  logic [ADDR_W-1:0] app_addr;
  logic [CMD_W-1:0]  app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_rdy,
    output app_wdf_wren, app_wdf_end, app_wdf_rdy,
    output app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input app_addr, app_cmd, app_en, app_rdy,
    input app_wdf_wren, app_wdf_end, app_wdf_rdy,
    input app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr_mon_trace_ram.sv
// Simple dual-port trace RAM: synchronous write, registered read (1-cycle latency).
module ddr_mon_trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 47,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset so the array can still map to block RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_app_monitor.sv
// Non-intrusive MIG app monitor: registers every app input once, then keeps saturating
// counters, outstanding-read tracking and a triggered circular trace of accepted commands.
module ddr_app_monitor
  import ddr_mon_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int CMD_W     = 3,
  parameter int TS_W      = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32,
  parameter int CNT_W     = 32,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int ENT_W    = entry_w(TS_W, CMD_W, ADDR_W)
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              init_calib_complete,
  ddr_app_monitor_if.slave  app,
  input  logic              clear,
  input  logic              arm,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] trig_mask,
  input  logic [CMD_W-1:0]  trig_cmd,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  wr_cmd_cnt,
  output logic [CNT_W-1:0]  rd_cmd_cnt,
  output logic [CNT_W-1:0]  wr_beat_cnt,
  output logic [CNT_W-1:0]  rd_beat_cnt,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              underflow_err,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ENT_W-1:0]  rd_entry,
  output logic [IDX_W:0]    trace_count
);

  localparam int TC_W = IDX_W + 1;
  localparam int PC_W = IDX_W + 1;

  // Stage 1: everything downstream sees only these registered copies.
  logic [ADDR_W-1:0] app_addr_q;
  logic [CMD_W-1:0]  app_cmd_q;
  logic app_en_q, app_rdy_q, app_wdf_wren_q, app_wdf_rdy_q;
  logic app_rd_data_valid_q, app_rd_data_end_q, calib_q;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      app_addr_q          <= '0;
      app_cmd_q           <= '0;
      app_en_q            <= 1'b0;
      app_rdy_q           <= 1'b0;
      app_wdf_wren_q      <= 1'b0;
      app_wdf_rdy_q       <= 1'b0;
      app_rd_data_valid_q <= 1'b0;
      app_rd_data_end_q   <= 1'b0;
      calib_q             <= 1'b0;
    end else begin
      app_addr_q          <= app.app_addr;
      app_cmd_q           <= app.app_cmd;
      app_en_q            <= app.app_en;
      app_rdy_q           <= app.app_rdy;
      app_wdf_wren_q      <= app.app_wdf_wren;
      app_wdf_rdy_q       <= app.app_wdf_rdy;
      app_rd_data_valid_q <= app.app_rd_data_valid;
      app_rd_data_end_q   <= app.app_rd_data_end;
      calib_q             <= init_calib_complete;
    end
  end

  logic cmd_acc, wr_acc, rd_acc, wbeat, rbeat, rend, trig_hit;
  assign cmd_acc  = app_en_q & app_rdy_q;
  assign wr_acc   = cmd_acc & (app_cmd_q == CMD_W'(CMD_WR));
  assign rd_acc   = cmd_acc & (app_cmd_q == CMD_W'(CMD_RD));
  assign wbeat    = app_wdf_wren_q & app_wdf_rdy_q;
  assign rbeat    = app_rd_data_valid_q;
  assign rend     = rbeat & app_rd_data_end_q;
  assign trig_hit = cmd_acc & (app_cmd_q == trig_cmd) &
                    (((app_addr_q ^ trig_addr) & trig_mask) == '0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] wr_cmd_q, wr_cmd_d, rd_cmd_q, rd_cmd_d;
  logic [CNT_W-1:0] wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             uflow_q, uflow_d;

  always_comb begin
    wr_cmd_d  = wr_cmd_q;
    rd_cmd_d  = rd_cmd_q;
    wr_beat_d = wr_beat_q;
    rd_beat_d = rd_beat_q;
    outst_d   = outst_q;
    uflow_d   = uflow_q;
    if (clear) begin
      wr_cmd_d  = '0;
      rd_cmd_d  = '0;
      wr_beat_d = '0;
      rd_beat_d = '0;
      outst_d   = '0;
      uflow_d   = 1'b0;
    end else if (calib_q) begin
      if (wr_acc) wr_cmd_d  = sat_inc(wr_cmd_q);
      if (rd_acc) rd_cmd_d  = sat_inc(rd_cmd_q);
      if (wbeat)  wr_beat_d = sat_inc(wr_beat_q);
      if (rbeat)  rd_beat_d = sat_inc(rd_beat_q);
      // A read issued and a read completed in the same cycle cancel out.
      if (rd_acc && !rend) begin
        outst_d = sat_inc(outst_q);
      end else if (rend && !rd_acc) begin
        if (outst_q == '0) uflow_d = 1'b1;
        else               outst_d = outst_q - CNT_W'(1);
      end
    end
  end

  logic [TS_W-1:0] ts_q;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wr_cmd_q  <= '0;
      rd_cmd_q  <= '0;
      wr_beat_q <= '0;
      rd_beat_q <= '0;
      outst_q   <= '0;
      uflow_q   <= 1'b0;
      ts_q      <= '0;
    end else begin
      wr_cmd_q  <= wr_cmd_d;
      rd_cmd_q  <= rd_cmd_d;
      wr_beat_q <= wr_beat_d;
      rd_beat_q <= rd_beat_d;
      outst_q   <= outst_d;
      uflow_q   <= uflow_d;
      ts_q      <= ts_q + TS_W'(1);
    end
  end

  mon_state_e       state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TC_W-1:0]  trace_cnt_q, trace_cnt_d;
  logic [PC_W-1:0]  post_cnt_q, post_cnt_d;
  logic             trace_we, restart;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // post_cnt counts the entries still owed after the one being written.
  always_comb begin
    state_d = state_q;
    if (calib_q) begin
      if (arm) begin
        state_d = ST_ARMED;
      end else begin
        unique case (state_q)
          ST_ARMED: if (trig_hit) state_d = (POST_TRIG == 1) ? ST_DONE : ST_POST;
          ST_POST:  if (cmd_acc && post_cnt_q == PC_W'(1)) state_d = ST_DONE;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    restart  = 1'b0;
    trace_we = 1'b0;
    if (calib_q) begin
      restart  = arm;
      trace_we = !arm && cmd_acc && (state_q == ST_ARMED || state_q == ST_POST);
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    trace_cnt_d = trace_cnt_q;
    post_cnt_d  = post_cnt_q;
    if (restart) begin
      wr_ptr_d    = '0;
      trace_cnt_d = '0;
    end else if (trace_we) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (trace_cnt_q != TC_W'(DEPTH)) trace_cnt_d = trace_cnt_q + TC_W'(1);
      if (state_q == ST_ARMED) post_cnt_d = PC_W'(POST_TRIG - 1);
      else                     post_cnt_d = post_cnt_q - PC_W'(1);
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wr_ptr_q    <= '0;
      trace_cnt_q <= '0;
      post_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      trace_cnt_q <= trace_cnt_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  logic [IDX_W-1:0] raddr;
  assign raddr = (trace_cnt_q == TC_W'(DEPTH)) ? wr_ptr_q + rd_idx : rd_idx;

  ddr_mon_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_trace_ram (
    .clk_i   (ui_clk),
    .rst_i   (ui_clk_sync_rst),
    .we_i    (trace_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({ts_q, app_cmd_q, app_addr_q}),
    .raddr_i (raddr),
    .rdata_o (rd_entry)
  );

  assign state          = state_q;
  assign wr_cmd_cnt     = wr_cmd_q;
  assign rd_cmd_cnt     = rd_cmd_q;
  assign wr_beat_cnt    = wr_beat_q;
  assign rd_beat_cnt    = rd_beat_q;
  assign rd_outstanding = outst_q;
  assign underflow_err  = uflow_q;
  assign trace_count    = trace_cnt_q;

endmodule

// File: tb/tb_ddr_app_monitor.sv
// Self-checking bench: directed table, directed trace sequences, randomized runs vs a queue model.
module tb_ddr_app_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, calib, clear, arm1, arm2;
  logic [27:0] trig_addr, trig_mask;
  logic [2:0]  trig_cmd;

  logic [1:0]  st1, st2;
  logic [31:0] wc1, rc1, wb1, rb1, os1;
  logic [2:0]  wc2, rc2, wb2, rb2, os2;
  logic        uf1, uf2;
  logic [5:0]  rd_idx1;
  logic [2:0]  rd_idx2;
  logic [46:0] ent1, ent2;
  logic [6:0]  tc1;
  logic [3:0]  tc2;

  ddr_app_monitor_if #(.ADDR_W(28), .CMD_W(3)) app_if ();

  ddr_app_monitor dut1 (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib), .app(app_if),
    .clear(clear), .arm(arm1), .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_cmd(trig_cmd),
    .state(st1), .wr_cmd_cnt(wc1), .rd_cmd_cnt(rc1), .wr_beat_cnt(wb1), .rd_beat_cnt(rb1),
    .rd_outstanding(os1), .underflow_err(uf1), .rd_idx(rd_idx1), .rd_entry(ent1), .trace_count(tc1)
  );

  ddr_app_monitor #(.DEPTH(8), .POST_TRIG(2), .CNT_W(3)) dut2 (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib), .app(app_if),
    .clear(clear), .arm(arm2), .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_cmd(trig_cmd),
    .state(st2), .wr_cmd_cnt(wc2), .rd_cmd_cnt(rc2), .wr_beat_cnt(wb2), .rd_beat_cnt(rb2),
    .rd_outstanding(os2), .underflow_err(uf2), .rd_idx(rd_idx2), .rd_entry(ent2), .trace_count(tc2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef enum int {K_WR, K_WBEAT, K_RD, K_REND, K_RDREND, K_BP, K_CLR} kind_e;
  typedef struct {
    kind_e kind;
    int    n;
    int    wc, rc, wb, rb, os, uf;
  } vec_t;

  typedef struct {
    logic [27:0] a;
    logic [2:0]  c;
    int          cyc;
  } acc_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    app_if.app_en            = 1'b0;
    app_if.app_rdy           = 1'b1;
    app_if.app_wdf_wren      = 1'b0;
    app_if.app_wdf_end       = 1'b0;
    app_if.app_wdf_rdy       = 1'b1;
    app_if.app_rd_data_valid = 1'b0;
    app_if.app_rd_data_end   = 1'b0;
    clear = 1'b0;
    arm1  = 1'b0;
    arm2  = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
    idle();
    app_if.app_en   = 1'b1;
    app_if.app_cmd  = c;
    app_if.app_addr = a;
    tick();
    idle();
  endtask

  task automatic read1(input int idx);
    rd_idx1 = 6'(idx);
    tick();
  endtask

  vec_t tbl[10];
  acc_t accq[$];

  initial begin
    int mwc, mrc, mwb, mrb, mos, muf;
    int m, n, cnt, first, exp_st;
    logic [15:0] ts0, prev_ts;
    int ridx[3];
    int raddr_exp[3];
    logic [27:0] sc_addr[4];
    logic [2:0]  sc_cmd[4];

    rst = 1'b1; calib = 1'b0; rd_idx1 = '0; rd_idx2 = '0;
    trig_addr = '0; trig_mask = '0; trig_cmd = '0;
    app_if.app_addr = '0; app_if.app_cmd = '0;
    idle();
    repeat (3) tick();

    check("rst_state1", st1, 0);   check("rst_state2", st2, 0);
    check("rst_wc", wc1, 0);       check("rst_rc", rc1, 0);
    check("rst_wb", wb1, 0);       check("rst_rb", rb1, 0);
    check("rst_os", os1, 0);       check("rst_uf", uf1, 0);
    check("rst_tc", tc1, 0);       check("rst_entry", ent1, 0);

    rst = 1'b0; calib = 1'b1;
    tick(); tick();

    tbl[0] = '{K_WR,     5, 5, 0, 0, 0, 0, 0};
    tbl[1] = '{K_WBEAT,  5, 5, 0, 5, 0, 0, 0};
    tbl[2] = '{K_RD,     3, 5, 3, 5, 0, 3, 0};
    tbl[3] = '{K_REND,   3, 5, 3, 5, 3, 0, 0};
    tbl[4] = '{K_BP,    10, 5, 3, 5, 3, 0, 0};
    tbl[5] = '{K_RD,     1, 5, 4, 5, 3, 1, 0};
    tbl[6] = '{K_RDREND, 1, 5, 5, 5, 4, 1, 0};
    tbl[7] = '{K_REND,   1, 5, 5, 5, 5, 0, 0};
    tbl[8] = '{K_REND,   1, 5, 5, 5, 6, 0, 1};
    tbl[9] = '{K_CLR,    1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        idle();
        case (tbl[i].kind)
          K_WR:     begin app_if.app_en = 1'b1; app_if.app_cmd = 3'd0; end
          K_WBEAT:  app_if.app_wdf_wren = 1'b1;
          K_RD:     begin app_if.app_en = 1'b1; app_if.app_cmd = 3'd1; end
          K_REND:   begin app_if.app_rd_data_valid = 1'b1; app_if.app_rd_data_end = 1'b1; end
          K_RDREND: begin
            app_if.app_en = 1'b1; app_if.app_cmd = 3'd1;
            app_if.app_rd_data_valid = 1'b1; app_if.app_rd_data_end = 1'b1;
          end
          K_BP:     begin app_if.app_en = 1'b1; app_if.app_cmd = 3'd1; app_if.app_rdy = 1'b0; end
          default:  clear = 1'b1;
        endcase
        tick();
      end
      idle();
      tick(); tick();
      check($sformatf("tbl%0d_wc", i), wc1, tbl[i].wc);
      check($sformatf("tbl%0d_rc", i), rc1, tbl[i].rc);
      check($sformatf("tbl%0d_wb", i), wb1, tbl[i].wb);
      check($sformatf("tbl%0d_rb", i), rb1, tbl[i].rb);
      check($sformatf("tbl%0d_os", i), os1, tbl[i].os);
      check($sformatf("tbl%0d_uf", i), uf1, tbl[i].uf);
    end

    // Random traffic against event totals; dut2 has 3-bit counters that must saturate.
    mwc = 0; mrc = 0; mwb = 0; mrb = 0; mos = 0; muf = 0;
    for (int i = 0; i < 400; i++) begin
      logic rd_a, rend_e;
      idle();
      app_if.app_en            = 1'($urandom_range(0, 1));
      app_if.app_rdy           = 1'($urandom_range(0, 1));
      app_if.app_cmd           = 3'($urandom_range(0, 2));
      app_if.app_addr          = 28'($urandom);
      app_if.app_wdf_wren      = 1'($urandom_range(0, 1));
      app_if.app_wdf_rdy       = 1'($urandom_range(0, 1));
      app_if.app_rd_data_valid = 1'($urandom_range(0, 1));
      app_if.app_rd_data_end   = ($urandom_range(0, 3) == 0);
      rd_a   = app_if.app_en && app_if.app_rdy && app_if.app_cmd == 3'd1;
      rend_e = app_if.app_rd_data_valid && app_if.app_rd_data_end;
      if (app_if.app_en && app_if.app_rdy && app_if.app_cmd == 3'd0) mwc++;
      if (rd_a) mrc++;
      if (app_if.app_wdf_wren && app_if.app_wdf_rdy) mwb++;
      if (app_if.app_rd_data_valid) mrb++;
      if (rd_a && !rend_e) mos++;
      else if (rend_e && !rd_a) begin
        if (mos == 0) muf = 1;
        else mos--;
      end
      tick();
    end
    idle();
    tick(); tick(); tick();
    check("rnd_wc", wc1, mwc); check("rnd_rc", rc1, mrc);
    check("rnd_wb", wb1, mwb); check("rnd_rb", rb1, mrb);
    check("rnd_os", os1, mos); check("rnd_uf", uf1, muf);
    check("sat_wc", wc2, (mwc > 7) ? 7 : mwc);
    check("sat_rc", rc2, (mrc > 7) ? 7 : mrc);
    check("sat_wb", wb2, (mwb > 7) ? 7 : mwb);
    check("sat_rb", rb2, (mrb > 7) ? 7 : mrb);

    // Calibration low freezes counting.
    calib = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) send_cmd(3'd0, 28'(i));
    tick(); tick();
    check("calib_freeze_wc", wc1, mwc);
    calib = 1'b1;
    tick(); tick();

    // Wrapped trigger capture: 110 reads addr=i, trigger on 70.
    trig_cmd = 3'd1; trig_mask = '1; trig_addr = 28'd70;
    idle(); arm1 = 1'b1; tick(); idle();
    check("arm_state", st1, 1);
    for (int i = 0; i < 110; i++) begin
      send_cmd(3'd1, 28'(i));
      if (i == 85) check("post_state", st1, 2);
    end
    tick(); tick();
    check("wrap_state", st1, 3);
    check("wrap_tc", tc1, 64);
    ridx = '{0, 32, 63};
    raddr_exp = '{38, 70, 101};
    for (int j = 0; j < 3; j++) begin
      read1(ridx[j]);
      check($sformatf("wrap_addr%0d", ridx[j]), ent1[27:0], raddr_exp[j]);
      check($sformatf("wrap_cmd%0d", ridx[j]), ent1[30:28], 1);
    end

    // Short capture on the small instance: trigger on the 3rd command, POST_TRIG=2.
    trig_addr = 28'd12;
    idle(); arm2 = 1'b1; tick(); idle();
    sc_addr = '{28'd10, 28'd11, 28'd12, 28'd13};
    sc_cmd  = '{3'd0, 3'd1, 3'd1, 3'd0};
    for (int j = 0; j < 4; j++) begin
      send_cmd(sc_cmd[j], sc_addr[j]);
      repeat (j + 1) tick();
    end
    send_cmd(3'd0, 28'd14);
    tick(); tick();
    check("short_state", st2, 3);
    check("short_tc", tc2, 4);
    prev_ts = '0;
    for (int j = 0; j < 4; j++) begin
      rd_idx2 = 3'(j);
      tick();
      check($sformatf("short_addr%0d", j), ent2[27:0], sc_addr[j]);
      check($sformatf("short_cmd%0d", j), ent2[30:28], sc_cmd[j]);
      if (j > 0) check($sformatf("short_ts_inc%0d", j), ent2[46:31] > prev_ts, 1);
      prev_ts = ent2[46:31];
    end

    // Randomized capture with a masked trigger, checked against a queue of accepted commands.
    trig_cmd = 3'd1; trig_mask = 28'hF; trig_addr = 28'hABC5;
    idle(); arm1 = 1'b1; tick(); idle();
    accq.delete();
    for (int i = 0; i < 1500; i++) begin
      idle();
      app_if.app_en   = 1'($urandom_range(0, 1));
      app_if.app_rdy  = ($urandom_range(0, 3) != 0);
      app_if.app_cmd  = 3'($urandom_range(0, 1));
      app_if.app_addr = 28'($urandom_range(0, 255));
      if (app_if.app_en && app_if.app_rdy)
        accq.push_back('{app_if.app_addr, app_if.app_cmd, cyc});
      tick();
    end
    idle();
    tick(); tick();
    m = -1;
    for (int j = 0; j < accq.size(); j++)
      if (m < 0 && accq[j].c == 3'd1 && accq[j].a[3:0] == 4'h5) m = j;
    exp_st = (m < 0) ? 1 : ((accq.size() >= m + 32) ? 3 : 2);
    check("rtrace_state", st1, exp_st);
    if (exp_st == 3) begin
      n = m + 32;
      cnt = (n > 64) ? 64 : n;
      first = n - cnt;
      check("rtrace_tc", tc1, cnt);
      ts0 = '0;
      for (int j = 0; j < cnt; j++) begin
        read1(j);
        check($sformatf("rtrace_addr%0d", j), ent1[27:0], accq[first + j].a);
        check($sformatf("rtrace_cmd%0d", j), ent1[30:28], accq[first + j].c);
        if (j == 0) ts0 = ent1[46:31];
        else check($sformatf("rtrace_ts%0d", j), 16'(ent1[46:31] - ts0),
                   16'(accq[first + j].cyc - accq[first].cyc));
      end
    end

    // Reset in the middle of POST, then a fresh capture.
    trig_mask = '1; trig_addr = 28'd5;
    idle(); arm1 = 1'b1; tick(); idle();
    send_cmd(3'd1, 28'd3); send_cmd(3'd1, 28'd5); send_cmd(3'd1, 28'd6);
    tick(); tick();
    check("pre_rst_state", st1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", st1, 0); check("mid_rst_tc", tc1, 0);
    check("mid_rst_wc", wc1, 0);    check("mid_rst_rc", rc1, 0);
    check("mid_rst_wb", wb1, 0);    check("mid_rst_rb", rb1, 0);
    check("mid_rst_os", os1, 0);    check("mid_rst_uf", uf1, 0);
    check("mid_rst_entry", ent1, 0);
    tick(); tick();
    trig_addr = 28'd105;
    idle(); arm1 = 1'b1; tick(); idle();
    for (int i = 0; i < 40; i++) send_cmd(3'd1, 28'(100 + i));
    tick(); tick();
    check("rearm_state", st1, 3);
    check("rearm_tc", tc1, 37);
    ridx = '{0, 5, 36};
    raddr_exp = '{100, 105, 136};
    for (int j = 0; j < 3; j++) begin
      read1(ridx[j]);
      check($sformatf("rearm_addr%0d", ridx[j]), ent1[27:0], raddr_exp[j]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
